// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg
//   Shared types and constants for the BCD conversion scheduler:
//   FSM state encoding, operand/result/shift-register widths, the number
//   of double-dabble steps, and the per-nibble add-3 correction helper.
package bcd_sched_pkg;

  localparam int BYTE_W  = 8;
  localparam int BCD_W   = 12;
  localparam int SHIFT_W = 20;
  localparam int STEPS   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // Double-dabble correction: a digit of 5 or more gets 3 added so that
  // the following left shift carries correctly into the next decade.
  function automatic logic [3:0] dabble_fix(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step
//   One combinational double-dabble step on the 20-bit conversion register.
//   Ports:
//     din  - register value before the step {hundreds, tens, units, byte}
//     dout - value after add-3 correction of the three BCD nibbles followed
//            by a 1-bit left shift
module bcd_dabble_step
  import bcd_sched_pkg::*;
(
  input  logic [SHIFT_W-1:0] din,
  output logic [SHIFT_W-1:0] dout
);

  logic [SHIFT_W-1:0] fixed;

  always_comb begin
    fixed = {dabble_fix(din[19:16]), dabble_fix(din[15:12]),
             dabble_fix(din[11:8]), din[7:0]};
    dout  = fixed << 1;
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler
//   Shared multi-cycle binary-to-BCD converter. Round-robin arbitration
//   among NUM_REQ requesters; the granted byte is converted into three BCD
//   digits with one double-dabble step per clock and returned tagged with
//   the requester id.
//   Ports:
//     clk      - system clock, rising edge
//     reset    - asynchronous active-high reset
//     req      - per-requester request level, held until its ack
//     byte_in  - flattened operands, requester k on [8k+7:8k]
//     ack      - one-cycle pulse, operand of requester k captured
//     busy     - high whenever the FSM is not idle
//     done     - one-cycle pulse, bcd_out/done_id valid
//     done_id  - requester id of the completed conversion
//     bcd_out  - {hundreds, tens, units}, held until the next done
//   Optional build macro BCD_CACHE_EN: per-requester cache of the last
//   operand/result; a repeated operand skips the shift sequence.
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] byte_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [BCD_W-1:0]          bcd_out
);

  localparam int unsigned     NR        = NUM_REQ;
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [2:0]      LAST_STEP = 3'(STEPS - 1);

  state_t             state;
  logic [SHIFT_W-1:0] shreg;
  logic [SHIFT_W-1:0] step_out;
  logic [2:0]         count;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gid;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic [BYTE_W-1:0]  gnt_byte;

`ifdef BCD_CACHE_EN
  localparam int unsigned NE = 2 ** ID_W;
  logic [NE-1:0]     c_vld;
  logic [BYTE_W-1:0] c_byte [NE];
  logic [BCD_W-1:0]  c_res  [NE];
  logic [BYTE_W-1:0] op_byte;
  logic              hit;
  logic              gnt_hit;

  assign gnt_hit = c_vld[gnt_id] && (c_byte[gnt_id] == gnt_byte);
`endif

  bcd_dabble_step u_step (
    .din  (shreg),
    .dout (step_out)
  );

  // Round-robin search upward from ptr with wrap-around; only ids below
  // NUM_REQ are ever visited, so invalid ids cannot be granted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!gnt_vld && req[(32'(ptr) + i) % NR]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'((32'(ptr) + i) % NR);
      end
    end
  end

  assign gnt_byte = byte_in[32'(gnt_id) * BYTE_W +: BYTE_W];
  assign next_ptr = (gid == LAST_ID) ? '0 : gid + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ack     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      bcd_out <= '0;
      ptr     <= '0;
      count   <= '0;
      gid     <= '0;
      shreg   <= '0;
`ifdef BCD_CACHE_EN
      c_vld   <= '0;
      op_byte <= '0;
      hit     <= 1'b0;
      for (int unsigned i = 0; i < NE; i++) begin
        c_byte[i] <= '0;
        c_res[i]  <= '0;
      end
`endif
    end else begin
      ack  <= '0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            shreg <= {{BCD_W{1'b0}}, gnt_byte};
            gid   <= gnt_id;
            count <= '0;
            ack   <= NUM_REQ'(1) << gnt_id;
            busy  <= 1'b1;
            state <= S_SHIFT;
`ifdef BCD_CACHE_EN
            op_byte <= gnt_byte;
            hit     <= gnt_hit;
`endif
          end
        end

        S_SHIFT: begin
`ifdef BCD_CACHE_EN
          // A cache hit spends exactly one cycle here before DONE so the
          // ack pulse and the done pulse never overlap.
          if (hit) begin
            state   <= S_DONE;
            done    <= 1'b1;
            done_id <= gid;
            bcd_out <= c_res[gid];
            ptr     <= next_ptr;
          end else
`endif
          begin
            shreg <= step_out;
            count <= count + 1'b1;
            if (count == LAST_STEP) begin
              state   <= S_DONE;
              done    <= 1'b1;
              done_id <= gid;
              bcd_out <= step_out[SHIFT_W-1 -: BCD_W];
              ptr     <= next_ptr;
`ifdef BCD_CACHE_EN
              c_vld[gid]  <= 1'b1;
              c_byte[gid] <= op_byte;
              c_res[gid]  <= step_out[SHIFT_W-1 -: BCD_W];
`endif
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler
//   Directed self-checking bench for bcd_convert_scheduler (NUM_REQ=3).
//   Build with BCD_CACHE_EN to exercise the result cache as well.
module tb_bcd_convert_scheduler;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req;
  logic [8*NUM_REQ-1:0]   byte_in;
  logic [NUM_REQ-1:0]     ack;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [11:0]            bcd_out;

  int checks = 0;
  int errors = 0;

  // bench-side model of the result cache (only consulted with BCD_CACHE_EN)
  bit        cvld  [NUM_REQ];
  logic [7:0] cbyte [NUM_REQ];

  typedef struct {
    int         id;
    logic [7:0] val;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [9];

  bcd_convert_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .byte_in (byte_in),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int exp_lat(input int k, input logic [7:0] b);
`ifdef BCD_CACHE_EN
    if (cvld[k] && cbyte[k] == b) return 1;
`endif
    return 8;
  endfunction

  task automatic clear_cache_model();
    for (int i = 0; i < NUM_REQ; i++) begin
      cvld[i]  = 1'b0;
      cbyte[i] = '0;
    end
  endtask

  // One request on requester k; checks ack, latency, result and id.
  task automatic convert(input int k, input logic [7:0] b, input logic [11:0] exp,
                         input string name, output int lat);
    bit got;
    int elat;
    logic [NUM_REQ-1:0] onehot;
    elat = exp_lat(k, b);
    onehot = '0;
    onehot[k] = 1'b1;
    @(negedge clk);
    byte_in[8*k +: 8] = b;
    req[k] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1'b1;
        chk({name, " ack"}, 32'(ack), 32'(onehot));
      end
    end
    chk({name, " ack seen"}, 32'(got), 32'd1);
    req[k] = 1'b0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    chk({name, " done seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(elat));
    chk({name, " bcd"}, 32'(bcd_out), 32'(exp));
    chk({name, " id"}, 32'(done_id), 32'(k));
    cvld[k]  = 1'b1;
    cbyte[k] = b;
  endtask

  initial begin
    int lat;
    int nd;
    int bad1;
    int busy_low;
    bit started;
    logic [ID_W-1:0] ids [9];
    logic [11:0]     res [9];

    vecs[0] = '{0, 8'd255, 12'h255};
    vecs[1] = '{1, 8'd0,   12'h000};
    vecs[2] = '{1, 8'd9,   12'h009};
    vecs[3] = '{1, 8'd10,  12'h010};
    vecs[4] = '{1, 8'd99,  12'h099};
    vecs[5] = '{1, 8'd100, 12'h100};
    vecs[6] = '{2, 8'd137, 12'h137};
    vecs[7] = '{0, 8'd58,  12'h058};
    vecs[8] = '{2, 8'd199, 12'h199};

    clear_cache_model();
    req = '0;
    byte_in = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset done_id", 32'(done_id), 32'd0);
    chk("reset bcd_out", 32'(bcd_out), 32'd0);
    reset = 1'b0;

    // simultaneous req0 and req2 with pointer at 0
    @(negedge clk);
    byte_in = {8'd34, 8'd77, 8'd12};
    req = 3'b101;
    nd = 0;
    bad1 = 0;
    for (int c = 0; c < 60 && nd < 2; c++) begin
      @(negedge clk);
      if (ack[1]) bad1++;
      if (ack[0]) req[0] = 1'b0;
      if (ack[2]) req[2] = 1'b0;
      if (done) begin
        ids[nd] = done_id;
        res[nd] = bcd_out;
        nd++;
      end
    end
    chk("simul count", 32'(nd), 32'd2);
    chk("simul first id", 32'(ids[0]), 32'd0);
    chk("simul first bcd", 32'(res[0]), 32'h012);
    chk("simul second id", 32'(ids[1]), 32'd2);
    chk("simul second bcd", 32'(res[1]), 32'h034);
    chk("simul req1 never acked", 32'(bad1), 32'd0);
    req = '0;
    cvld[0] = 1'b1; cbyte[0] = 8'd12;
    cvld[2] = 1'b1; cbyte[2] = 8'd34;

    // all requesters held: round-robin 0,1,2,... over 9 conversions
    @(negedge clk);
    byte_in = {8'd3, 8'd2, 8'd1};
    req = 3'b111;
    nd = 0;
    busy_low = 0;
    started = 1'b0;
    for (int c = 0; c < 300 && nd < 9; c++) begin
      @(negedge clk);
      if (ack != '0) started = 1'b1;
      if (started && !busy) busy_low++;
      if (done) begin
        ids[nd] = done_id;
        res[nd] = bcd_out;
        nd++;
      end
    end
    req = '0;
    chk("rr count", 32'(nd), 32'd9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("rr id %0d", i), 32'(ids[i]), 32'(i % 3));
      chk($sformatf("rr bcd %0d", i), 32'(res[i]), 32'((i % 3) + 1));
    end
    chk("rr idle gaps", 32'(busy_low), 32'd8);
    for (int i = 0; i < NUM_REQ; i++) begin
      cvld[i] = 1'b1;
      cbyte[i] = 8'(i + 1);
    end

    // table of directed vectors
    for (int i = 0; i < 9; i++)
      convert(vecs[i].id, vecs[i].val, vecs[i].exp, $sformatf("vec %0d", i), lat);

    // full sweep on requester 1 against the reference model
    for (int v = 0; v < 256; v++)
      convert(1, 8'(v), ref_bcd(v), $sformatf("sweep %0d", v), lat);

    // reset in the middle of SHIFT
    @(negedge clk);
    byte_in[7:0] = 8'd200;
    req[0] = 1'b1;
    nd = 0;
    for (int c = 0; c < 30 && nd == 0; c++) begin
      @(negedge clk);
      if (ack[0]) nd = 1;
    end
    chk("midreset ack", 32'(nd), 32'd1);
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset bcd_out", 32'(bcd_out), 32'd0);
    chk("midreset done_id", 32'(done_id), 32'd0);
    chk("midreset ack clear", 32'(ack), 32'd0);
    clear_cache_model();
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midreset no done", 32'(nd), 32'd0);
    convert(1, 8'd137, 12'h137, "after reset", lat);

`ifdef BCD_CACHE_EN
    convert(1, 8'd42, 12'h042, "cache miss 42", lat);
    chk("cache miss latency", 32'(lat), 32'd8);
    convert(1, 8'd42, 12'h042, "cache hit 42", lat);
    chk("cache hit latency", 32'(lat), 32'd1);
    convert(1, 8'd43, 12'h043, "cache miss 43", lat);
    chk("cache 43 latency", 32'(lat), 32'd8);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
